// File: rtl/ml_regression_pkg.sv
// Shared constants, byte masks, field layout and FSM state type for the feature packer.
// Optional checksum build: ML_REGRESSION_CKSUM_EN.
package ml_regression_pkg;

    localparam int unsigned FRAME_BYTES = 11;
    localparam int unsigned WORD_W      = 8 * FRAME_BYTES;

    // Element [k] is the keep-mask for byte k of the frame.
    localparam logic [FRAME_BYTES-1:0][7:0] BYTE_MASK = {
        8'h03, 8'h7F, 8'hFF, 8'h01, 8'hFF, 8'h01,
        8'hFF, 8'h0F, 8'hFF, 8'h03, 8'hFF
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_CHECK,
        ST_HOLD
    } state_t;

    localparam int unsigned NUM_FIELDS = 7;
    localparam int unsigned FIELD_OFF [NUM_FIELDS] = '{0, 16, 24, 32, 48, 64, 80};
    localparam int unsigned FIELD_W   [NUM_FIELDS] = '{10, 8, 4, 9, 9, 15, 2};

    function automatic logic [WORD_W-1:0] field_mask();
        logic [WORD_W-1:0] m;
        m = '0;
        for (int unsigned f = 0; f < NUM_FIELDS; f++) begin
            for (int unsigned b = 0; b < FIELD_W[f]; b++) begin
                m[FIELD_OFF[f] + b] = 1'b1;
            end
        end
        return m;
    endfunction

    localparam logic [WORD_W-1:0] FIELD_MASK = field_mask();

endpackage

// File: rtl/ml_regression_feature_packer_if.sv
// Byte-stream input and feature-word output handshakes of the feature packer.
// slave = packer side, master = producer/consumer side.
interface ml_regression_feature_packer_if;
    import ml_regression_pkg::*;

    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic [WORD_W-1:0] feat_word;
    logic              feat_valid;
    logic              feat_ready;

    modport slave (
        input  s_data, s_valid, feat_ready,
        output s_ready, feat_word, feat_valid
    );

    modport master (
        output s_data, s_valid, feat_ready,
        input  s_ready, feat_word, feat_valid
    );

endinterface

// File: rtl/ml_regression_byte_timer.sv
// Inter-byte timeout counter: counts enabled run cycles, cleared by clr_i; expired_o is
// combinational on the TIMEOUT_CYCLES-th idle cycle. TIMEOUT_CYCLES = 0 never expires.
module ml_regression_byte_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic enb,
    input  logic run_i,
    input  logic clr_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired_o = (TIMEOUT_CYCLES != 0) && run_i && !clr_i && (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !run_i || expired_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (enb) begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ml_regression_feature_packer.sv
// Packs 11 masked bytes into the 88-bit feature word; valid one cycle after the last byte,
// s_ready low while the word waits for feat_ready. Checksum byte via ML_REGRESSION_CKSUM_EN.
module ml_regression_feature_packer
    import ml_regression_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic enb,
    ml_regression_feature_packer_if.slave bus,
    output logic timeout_err,
    output logic cksum_err
);

    localparam int unsigned IDX_W = $clog2(FRAME_BYTES + 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              s_ready_q, s_ready_d;
    logic              tmo_err_q, tmo_err_d;
    logic              byte_xfer, word_xfer, in_frame, tmo_expired;
`ifdef ML_REGRESSION_CKSUM_EN
    logic [7:0]        xor_q, xor_d;
    logic              cks_err_q, cks_err_d;
`endif

    assign byte_xfer = enb & bus.s_valid & s_ready_q;
    assign word_xfer = enb & (state_q == ST_HOLD) & bus.feat_ready;
    assign in_frame  = (state_q == ST_COLLECT) || (state_q == ST_CHECK);

    ml_regression_byte_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_byte_timer (
        .clk       (clk),
        .reset     (reset),
        .enb       (enb),
        .run_i     (in_frame),
        .clr_i     (byte_xfer),
        .expired_o (tmo_expired)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        word_d    = word_q;
        tmo_err_d = 1'b0;
`ifdef ML_REGRESSION_CKSUM_EN
        xor_d     = xor_q;
        cks_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (byte_xfer) begin
                    word_d      = '0;
                    word_d[7:0] = bus.s_data & BYTE_MASK[0];
                    idx_d       = IDX_W'(1);
                    state_d     = ST_COLLECT;
`ifdef ML_REGRESSION_CKSUM_EN
                    xor_d       = bus.s_data;
`endif
                end
            end
            ST_COLLECT: begin
                if (byte_xfer) begin
                    for (int k = 1; k < FRAME_BYTES; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            word_d[8*k +: 8] = bus.s_data & BYTE_MASK[k];
                        end
                    end
                    idx_d = idx_q + 1'b1;
`ifdef ML_REGRESSION_CKSUM_EN
                    xor_d = xor_q ^ bus.s_data;
                    if (idx_q == IDX_W'(FRAME_BYTES - 1)) state_d = ST_CHECK;
`else
                    if (idx_q == IDX_W'(FRAME_BYTES - 1)) state_d = ST_HOLD;
`endif
                end else if (tmo_expired) begin
                    state_d   = ST_IDLE;
                    idx_d     = '0;
                    word_d    = '0;
                    tmo_err_d = 1'b1;
                end
            end
`ifdef ML_REGRESSION_CKSUM_EN
            ST_CHECK: begin
                if (byte_xfer) begin
                    if (bus.s_data == xor_q) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d   = ST_IDLE;
                        idx_d     = '0;
                        word_d    = '0;
                        cks_err_d = 1'b1;
                    end
                end else if (tmo_expired) begin
                    state_d   = ST_IDLE;
                    idx_d     = '0;
                    word_d    = '0;
                    tmo_err_d = 1'b1;
                end
            end
`endif
            ST_HOLD: begin
                // Word stays put after hand-off; it is cleared only when the next frame starts.
                if (word_xfer) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                word_d  = '0;
            end
        endcase
        s_ready_d = (state_d != ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            word_q    <= '0;
            s_ready_q <= 1'b0;
            tmo_err_q <= 1'b0;
`ifdef ML_REGRESSION_CKSUM_EN
            xor_q     <= '0;
            cks_err_q <= 1'b0;
`endif
        end else if (enb) begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            s_ready_q <= s_ready_d;
            tmo_err_q <= tmo_err_d;
`ifdef ML_REGRESSION_CKSUM_EN
            xor_q     <= xor_d;
            cks_err_q <= cks_err_d;
`endif
        end
    end

    assign bus.s_ready    = s_ready_q;
    assign bus.feat_valid = (state_q == ST_HOLD);
    assign bus.feat_word  = word_q & FIELD_MASK;
    assign timeout_err    = tmo_err_q;
`ifdef ML_REGRESSION_CKSUM_EN
    assign cksum_err      = cks_err_q;
`else
    assign cksum_err      = 1'b0;
`endif

endmodule

// File: tb/tb_ml_regression_feature_packer.sv
// Directed bench for ml_regression_feature_packer (timeout shortened to 16 cycles).
module tb_ml_regression_feature_packer;
    import ml_regression_pkg::*;

    localparam int unsigned TMO = 16;
`ifdef ML_REGRESSION_CKSUM_EN
    localparam int NB = FRAME_BYTES + 1;
`else
    localparam int NB = FRAME_BYTES;
`endif
    localparam logic [WORD_W-1:0] W_FF  = 88'h037FFF01FF01FF0FFF03FF;
    localparam logic [WORD_W-1:0] W_INC = 88'h030A090007000504030201;

    logic clk = 1'b0;
    logic reset, enb, timeout_err, cksum_err;
    int   checks = 0;
    int   errors = 0;
    int   edges  = 0;
    bit   toggle_enb = 1'b0;

    ml_regression_feature_packer_if bus();

    ml_regression_feature_packer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .enb         (enb),
        .bus         (bus),
        .timeout_err (timeout_err),
        .cksum_err   (cksum_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        bit acc;
        int guard;
        acc = 1'b0;
        guard = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        while (!acc && guard < 64) begin
            if (toggle_enb) enb = ~enb;
            acc = enb && bus.s_ready;
            tick();
            edges++;
            guard++;
        end
        bus.s_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL byte_accept: byte %02h not accepted after %0d cycles", d, guard);
        end
    endtask

    task automatic send_seq(input logic [7:0] first, input logic [7:0] step, input int n);
        for (int i = 0; i < n; i++) send_byte(8'(first + step * i));
    endtask

    // Sends a full frame; the checksum byte is appended when the feature is compiled in.
    task automatic send_frame(input logic [7:0] first, input logic [7:0] step);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < FRAME_BYTES; i++) x = x ^ 8'(first + step * i);
        send_seq(first, step, FRAME_BYTES);
`ifdef ML_REGRESSION_CKSUM_EN
        send_byte(x);
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1; enb = 1'b1; bus.s_valid = 1'b0; bus.s_data = 8'h00; bus.feat_ready = 1'b0;
        tick(); tick();
        checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b want 0", bus.s_ready); end
        checks++; if (bus.feat_valid !== 1'b0) begin errors++; $display("FAIL rst_feat_valid: got %b want 0", bus.feat_valid); end
        checks++; if (bus.feat_word !== '0) begin errors++; $display("FAIL rst_feat_word: got %h want 0", bus.feat_word); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_err: got %b want 0", timeout_err); end
        checks++; if (cksum_err !== 1'b0) begin errors++; $display("FAIL rst_cksum_err: got %b want 0", cksum_err); end
        reset = 1'b0;
        tick();
        checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL rst_release_s_ready: got %b want 1", bus.s_ready); end
    endtask

    task automatic test_all_ff();
        bus.feat_ready = 1'b1;
        send_frame(8'hFF, 8'h00);
        checks++; if (bus.feat_valid !== 1'b1 || bus.s_ready !== 1'b0) begin errors++; $display("FAIL ff_valid: valid=%b s_ready=%b want 1/0", bus.feat_valid, bus.s_ready); end
        checks++; if (bus.feat_word !== W_FF) begin errors++; $display("FAIL ff_word: got %h want %h", bus.feat_word, W_FF); end
        tick();
        checks++; if (bus.feat_valid !== 1'b0 || bus.s_ready !== 1'b1) begin errors++; $display("FAIL ff_accept: valid=%b s_ready=%b want 0/1", bus.feat_valid, bus.s_ready); end
    endtask

    task automatic test_hold_backpressure();
        bus.feat_ready = 1'b0;
        send_frame(8'h01, 8'h01);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (bus.feat_valid !== 1'b1 || bus.s_ready !== 1'b0 || bus.feat_word !== W_INC || timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: valid=%b s_ready=%b tmo=%b word=%h want 1/0/0 %h", i, bus.feat_valid, bus.s_ready, timeout_err, bus.feat_word, W_INC);
            end
            tick();
        end
        bus.feat_ready = 1'b1;
        tick();
        checks++; if (bus.feat_valid !== 1'b0 || bus.s_ready !== 1'b1) begin errors++; $display("FAIL hold_release: valid=%b s_ready=%b want 0/1", bus.feat_valid, bus.s_ready); end
    endtask

    task automatic test_timeout();
        bus.feat_ready = 1'b1;
        send_seq(8'hA5, 8'h00, 5);
        for (int i = 1; i <= int'(TMO); i++) begin
            tick();
            checks++;
            if (timeout_err !== (i == int'(TMO))) begin
                errors++;
                $display("FAIL timeout_idle%0d: timeout_err=%b want %b", i, timeout_err, (i == int'(TMO)));
            end
        end
        checks++; if (bus.s_ready !== 1'b1 || bus.feat_valid !== 1'b0) begin errors++; $display("FAIL timeout_state: s_ready=%b valid=%b want 1/0", bus.s_ready, bus.feat_valid); end
        tick();
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_pulse_width: got %b want 0", timeout_err); end
        send_frame(8'hFF, 8'h00);
        checks++; if (bus.feat_valid !== 1'b1 || bus.feat_word !== W_FF) begin errors++; $display("FAIL timeout_next_frame: valid=%b word=%h want 1 %h", bus.feat_valid, bus.feat_word, W_FF); end
        tick();
    endtask

    task automatic test_cksum();
        bus.feat_ready = 1'b1;
`ifdef ML_REGRESSION_CKSUM_EN
        send_seq(8'hFF, 8'h00, FRAME_BYTES);
        send_byte(8'hFF);
        checks++; if (bus.feat_valid !== 1'b1 || bus.feat_word !== W_FF) begin errors++; $display("FAIL cksum_good: valid=%b word=%h want 1 %h", bus.feat_valid, bus.feat_word, W_FF); end
        tick();
        send_seq(8'hFF, 8'h00, FRAME_BYTES);
        send_byte(8'h00);
        checks++; if (cksum_err !== 1'b1 || bus.feat_valid !== 1'b0 || bus.s_ready !== 1'b1) begin errors++; $display("FAIL cksum_bad: err=%b valid=%b s_ready=%b want 1/0/1", cksum_err, bus.feat_valid, bus.s_ready); end
        tick();
        checks++; if (cksum_err !== 1'b0 || bus.feat_valid !== 1'b0) begin errors++; $display("FAIL cksum_bad_after: err=%b valid=%b want 0/0", cksum_err, bus.feat_valid); end
`else
        send_seq(8'h00, 8'h00, FRAME_BYTES);
        checks++; if (cksum_err !== 1'b0 || bus.feat_valid !== 1'b1 || bus.feat_word !== '0) begin errors++; $display("FAIL zero_frame: err=%b valid=%b word=%h want 0/1 0", cksum_err, bus.feat_valid, bus.feat_word); end
        tick();
`endif
    endtask

    task automatic test_reset_midframe();
        bus.feat_ready = 1'b1;
        send_seq(8'hFF, 8'h00, 7);
        reset = 1'b1;
        tick();
        checks++;
        if (bus.s_ready !== 1'b0 || bus.feat_valid !== 1'b0 || bus.feat_word !== '0 || timeout_err !== 1'b0 || cksum_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_values: s_ready=%b valid=%b word=%h tmo=%b cks=%b want all 0", bus.s_ready, bus.feat_valid, bus.feat_word, timeout_err, cksum_err);
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL midreset_no_tmo%0d: got %b want 0", i, timeout_err); end
        end
        send_frame(8'hFF, 8'h00);
        checks++; if (bus.feat_valid !== 1'b1 || bus.feat_word !== W_FF) begin errors++; $display("FAIL midreset_frame: valid=%b word=%h want 1 %h", bus.feat_valid, bus.feat_word, W_FF); end
        tick();
    endtask

    task automatic test_enb_toggle();
        bus.feat_ready = 1'b1;
        enb = 1'b1;
        edges = 0;
        toggle_enb = 1'b1;
        send_frame(8'h01, 8'h01);
        toggle_enb = 1'b0;
        checks++; if (edges !== 2 * NB) begin errors++; $display("FAIL enb_cycles: got %0d want %0d", edges, 2 * NB); end
        checks++; if (bus.feat_valid !== 1'b1 || bus.feat_word !== W_INC) begin errors++; $display("FAIL enb_word: valid=%b word=%h want 1 %h", bus.feat_valid, bus.feat_word, W_INC); end
        enb = 1'b0;
        tick();
        checks++; if (bus.feat_valid !== 1'b1 || bus.s_ready !== 1'b0) begin errors++; $display("FAIL enb_hold: valid=%b s_ready=%b want 1/0", bus.feat_valid, bus.s_ready); end
        enb = 1'b1;
        tick();
        checks++; if (bus.feat_valid !== 1'b0 || bus.s_ready !== 1'b1) begin errors++; $display("FAIL enb_release: valid=%b s_ready=%b want 0/1", bus.feat_valid, bus.s_ready); end
    endtask

    task automatic test_back_to_back();
        bus.feat_ready = 1'b1;
        enb = 1'b1;
        edges = 0;
        send_frame(8'hFF, 8'h00);
        send_frame(8'h01, 8'h01);
        checks++; if (edges !== 2 * NB + 1) begin errors++; $display("FAIL b2b_cycles: got %0d want %0d", edges, 2 * NB + 1); end
        checks++; if (bus.feat_valid !== 1'b1 || bus.feat_word !== W_INC) begin errors++; $display("FAIL b2b_word: valid=%b word=%h want 1 %h", bus.feat_valid, bus.feat_word, W_INC); end
        tick();
    endtask

    initial begin
        test_reset();
        test_all_ff();
        test_hold_backpressure();
        test_timeout();
        test_cksum();
        test_reset_midframe();
        test_enb_toggle();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
